// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store stage: funct3 width codes, FSM encoding,
// byte-lane strobe masks and access-size helpers.
package lsu_mem_stage_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_t;

   localparam logic [3:0] WSTRB_NONE = 4'b0000;
   localparam logic [3:0] WSTRB_B    = 4'b0001;
   localparam logic [3:0] WSTRB_HLO  = 4'b0011;
   localparam logic [3:0] WSTRB_HHI  = 4'b1100;
   localparam logic [3:0] WSTRB_W    = 4'b1111;

   // Undefined width codes fall through to a full-word access.
   function automatic size_t f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: f3_size = SZ_B;
         F3_H, F3_HU: f3_size = SZ_H;
         default:     f3_size = SZ_W;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3_size(f3))
         SZ_H:    is_misaligned = off[0];
         SZ_W:    is_misaligned = (off != 2'b00);
         default: is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational lane logic: store data replication / strobe generation and
// load byte/half extraction with sign or zero extension.
module lsu_mem_stage_align
   import lsu_mem_stage_pkg::*;
(
   input  logic [2:0]  i_st_f3,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_st_wdata,
   output logic [3:0]  o_st_wstrb,
   input  logic [2:0]  i_ld_f3,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_ld_rdata,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sext;

   assign w_byte = i_ld_rdata[{i_ld_off, 3'b000} +: 8];
   assign w_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
   // BU/HU have funct3[2] set; B/H sign-extend.
   assign w_sext = ~i_ld_f3[2];

   always_comb begin
      o_st_wdata = i_st_data;
      o_st_wstrb = WSTRB_W;
      case (f3_size(i_st_f3))
         SZ_B: begin
            o_st_wdata = {4{i_st_data[7:0]}};
            o_st_wstrb = WSTRB_B << i_st_off;
         end
         SZ_H: begin
            o_st_wdata = {2{i_st_data[15:0]}};
            o_st_wstrb = i_st_off[1] ? WSTRB_HHI : WSTRB_HLO;
         end
         default: ;
      endcase
   end

   always_comb begin
      o_ld_data = i_ld_rdata;
      case (f3_size(i_ld_f3))
         SZ_B:    o_ld_data = {{24{w_sext & w_byte[7]}}, w_byte};
         SZ_H:    o_ld_data = {{16{w_sext & w_half[15]}}, w_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage after the ALU: issues one req/ack data-memory transaction per
// aligned memory op and returns a single registered write-back beat per accepted op.
module lsu_mem_stage
   import lsu_mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [2:0]  funct3,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [4:0]  rd_in,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_wstrb,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        misalign,
   output logic        bus_err,
   output state_t      dbg_state
);

   // EX handshake: an op transfers on a cycle where ex_valid and ex_ready are both 1;
   // ex_ready is 1 only in IDLE, so EX must hold its op steady while ex_ready is 0.
   // The memory side holds dm_req and all dm_* stable until dm_ack is seen.

   state_t        r_state, w_state_nxt;
   logic          r_dm_req, w_dm_req_nxt;
   logic          r_dm_we, w_dm_we_nxt;
   logic [31:0]   r_dm_addr, w_dm_addr_nxt;
   logic [31:0]   r_dm_wdata, w_dm_wdata_nxt;
   logic [3:0]    r_dm_wstrb, w_dm_wstrb_nxt;
   logic          r_wb_valid, w_wb_valid_nxt;
   logic [31:0]   r_wb_data, w_wb_data_nxt;
   logic [4:0]    r_wb_rd, w_wb_rd_nxt;
   logic          r_misalign, w_misalign_nxt;
   logic          r_bus_err, w_bus_err_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]    r_f3, w_f3_nxt;
   logic [1:0]    r_off, w_off_nxt;
   logic [4:0]    r_rd, w_rd_nxt;

   logic          w_accept;
   logic          w_is_mem;
   logic          w_is_store;
   logic          w_misal;
   logic [31:0]   w_st_wdata;
   logic [3:0]    w_st_wstrb;
   logic [31:0]   w_ld_data;

   assign ex_ready   = (r_state == ST_IDLE);
   assign w_accept   = ex_valid & ex_ready;
   assign w_is_mem   = mem_read | mem_write;
   // A read-and-write op is treated as a load.
   assign w_is_store = mem_write & ~mem_read;
   assign w_misal    = is_misaligned(funct3, alu_result[1:0]);

   lsu_mem_stage_align u_align (
      .i_st_f3    (funct3),
      .i_st_off   (alu_result[1:0]),
      .i_st_data  (store_data),
      .o_st_wdata (w_st_wdata),
      .o_st_wstrb (w_st_wstrb),
      .i_ld_f3    (r_f3),
      .i_ld_off   (r_off),
      .i_ld_rdata (dm_rdata),
      .o_ld_data  (w_ld_data)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_dm_req_nxt   = r_dm_req;
      w_dm_we_nxt    = r_dm_we;
      w_dm_addr_nxt  = r_dm_addr;
      w_dm_wdata_nxt = r_dm_wdata;
      w_dm_wstrb_nxt = r_dm_wstrb;
      w_wb_valid_nxt = 1'b0;
      w_wb_data_nxt  = r_wb_data;
      w_wb_rd_nxt    = r_wb_rd;
      w_misalign_nxt = 1'b0;
      w_bus_err_nxt  = 1'b0;
      w_cnt_nxt      = r_cnt;
      w_f3_nxt       = r_f3;
      w_off_nxt      = r_off;
      w_rd_nxt       = r_rd;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (!w_is_mem) begin
                  w_wb_valid_nxt = 1'b1;
                  w_wb_data_nxt  = alu_result;
                  w_wb_rd_nxt    = rd_in;
               end else if (w_misal) begin
                  w_wb_valid_nxt = 1'b1;
                  w_misalign_nxt = 1'b1;
                  w_wb_data_nxt  = 32'h0;
                  w_wb_rd_nxt    = 5'd0;
               end else begin
                  w_state_nxt    = ST_BUSY;
                  w_dm_req_nxt   = 1'b1;
                  w_dm_we_nxt    = w_is_store;
                  w_dm_addr_nxt  = {alu_result[31:2], 2'b00};
                  w_dm_wdata_nxt = w_is_store ? w_st_wdata : 32'h0;
                  w_dm_wstrb_nxt = w_is_store ? w_st_wstrb : WSTRB_NONE;
                  w_cnt_nxt      = '0;
                  w_f3_nxt       = funct3;
                  w_off_nxt      = alu_result[1:0];
                  w_rd_nxt       = rd_in;
               end
            end
         end
         ST_BUSY: begin
            // An ack arriving in the final timeout cycle still completes normally.
            if (dm_ack) begin
               w_state_nxt    = ST_IDLE;
               w_dm_req_nxt   = 1'b0;
               w_dm_we_nxt    = 1'b0;
               w_dm_wstrb_nxt = WSTRB_NONE;
               w_wb_valid_nxt = 1'b1;
               w_wb_data_nxt  = r_dm_we ? 32'h0 : w_ld_data;
               w_wb_rd_nxt    = r_dm_we ? 5'd0 : r_rd;
            end else if (r_cnt == CW'(TIMEOUT)) begin
               w_state_nxt    = ST_IDLE;
               w_dm_req_nxt   = 1'b0;
               w_dm_we_nxt    = 1'b0;
               w_dm_wstrb_nxt = WSTRB_NONE;
               w_wb_valid_nxt = 1'b1;
               w_bus_err_nxt  = 1'b1;
               w_wb_data_nxt  = 32'h0;
               w_wb_rd_nxt    = 5'd0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_dm_req   <= 1'b0;
         r_dm_we    <= 1'b0;
         r_dm_addr  <= 32'h0;
         r_dm_wdata <= 32'h0;
         r_dm_wstrb <= WSTRB_NONE;
         r_wb_valid <= 1'b0;
         r_wb_data  <= 32'h0;
         r_wb_rd    <= 5'd0;
         r_misalign <= 1'b0;
         r_bus_err  <= 1'b0;
         r_cnt      <= '0;
         r_f3       <= 3'b000;
         r_off      <= 2'b00;
         r_rd       <= 5'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_dm_req   <= w_dm_req_nxt;
         r_dm_we    <= w_dm_we_nxt;
         r_dm_addr  <= w_dm_addr_nxt;
         r_dm_wdata <= w_dm_wdata_nxt;
         r_dm_wstrb <= w_dm_wstrb_nxt;
         r_wb_valid <= w_wb_valid_nxt;
         r_wb_data  <= w_wb_data_nxt;
         r_wb_rd    <= w_wb_rd_nxt;
         r_misalign <= w_misalign_nxt;
         r_bus_err  <= w_bus_err_nxt;
         r_cnt      <= w_cnt_nxt;
         r_f3       <= w_f3_nxt;
         r_off      <= w_off_nxt;
         r_rd       <= w_rd_nxt;
      end
   end

   assign dm_req    = r_dm_req;
   assign dm_we     = r_dm_we;
   assign dm_addr   = r_dm_addr;
   assign dm_wdata  = r_dm_wdata;
   assign dm_wstrb  = r_dm_wstrb;
   assign wb_valid  = r_wb_valid;
   assign wb_data   = r_wb_data;
   assign wb_rd     = r_wb_rd;
   assign misalign  = r_misalign;
   assign bus_err   = r_bus_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: vector table of single ops plus hand-written sequences
// for back-pressure, timeout, idle ack and asynchronous reset mid-transaction.
module tb_lsu_mem_stage;
   import lsu_mem_stage_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic [2:0]  funct3;
   logic        mem_read;
   logic        mem_write;
   logic [4:0]  rd_in;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        misalign;
   logic        bus_err;
   state_t      dbg_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   lsu_mem_stage #(.TIMEOUT(TO), .CW(8)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .alu_result (alu_result),
      .store_data (store_data),
      .funct3     (funct3),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .rd_in      (rd_in),
      .dm_req     (dm_req),
      .dm_we      (dm_we),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_wstrb   (dm_wstrb),
      .dm_rdata   (dm_rdata),
      .dm_ack     (dm_ack),
      .wb_valid   (wb_valid),
      .wb_data    (wb_data),
      .wb_rd      (wb_rd),
      .misalign   (misalign),
      .bus_err    (bus_err),
      .dbg_state  (dbg_state)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   int          cur_vec = -1;
   logic [38:0] exp_q[$];   // {wb_data, wb_rd, misalign, bus_err}
   logic [38:0] mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (vec %0d): got %h, expected %h", name, cur_vec, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn === 1'b1 && wb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_unexpected (vec %0d): got data %h rd %0d, expected no write-back",
                     cur_vec, wb_data, wb_rd);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_data",  wb_data, mon_e[38:7]);
            chk("wb_rd",    {27'd0, wb_rd}, {27'd0, mon_e[6:2]});
            chk("misalign", {31'd0, misalign}, {31'd0, mon_e[1]});
            chk("bus_err",  {31'd0, bus_err}, {31'd0, mon_e[0]});
         end
      end
   end

   // ---------------- vectors ----------------
   typedef struct {
      logic [31:0] alu;
      logic [31:0] sd;
      logic [2:0]  f3;
      logic        rdq;
      logic        wrq;
      logic [4:0]  rd;
      int          dly;      // BUSY cycle index of the ack (0 = first)
      logic [31:0] rdata;
      logic        mem;      // a memory transaction is expected
      logic [31:0] e_addr;
      logic        e_we;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [31:0] e_data;
      logic [4:0]  e_rd;
      logic        e_mis;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   // ---------------- driver tasks ----------------
   task automatic drive_op(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                           input logic rdq, input logic wrq, input logic [4:0] rd);
      alu_result = alu;
      store_data = sd;
      funct3     = f3;
      mem_read   = rdq;
      mem_write  = wrq;
      rd_in      = rd;
      ex_valid   = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int lows;
      @(negedge clk);
      drive_op(v.alu, v.sd, v.f3, v.rdq, v.wrq, v.rd);
      exp_q.push_back({v.e_data, v.e_rd, v.e_mis, 1'b0});
      @(negedge clk);
      ex_valid = 1'b0;
      if (v.mem) begin
         chk("dm_req_issue", {31'd0, dm_req}, 32'd1);
         chk("dm_addr", dm_addr, v.e_addr);
         chk("dm_we", {31'd0, dm_we}, {31'd0, v.e_we});
         chk("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, v.e_strb});
         if (v.e_we) chk("dm_wdata", dm_wdata, v.e_wdata);
         lows = 0;
         for (int i = 0; i < v.dly; i++) begin
            if (!ex_ready) lows++;
            @(negedge clk);
            chk("dm_addr_hold", dm_addr, v.e_addr);
         end
         if (!ex_ready) lows++;
         dm_ack   = 1'b1;
         dm_rdata = v.rdata;
         @(negedge clk);
         dm_ack   = 1'b0;
         dm_rdata = $urandom();
         chk("busy_cycles", lows, v.dly + 1);
         chk("dm_req_drop", {31'd0, dm_req}, 32'd0);
      end else begin
         chk("dm_req_none", {31'd0, dm_req}, 32'd0);
      end
      chk("wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("ex_ready_after", {31'd0, ex_ready}, 32'd1);
   endtask

   // ---------------- test ----------------
   int req_cnt;
   int guard;

   initial begin
      vecs[0]  = '{32'h1234_5678, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 0, 32'h0, 1'b0,
                   32'h0, 1'b0, 4'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b0};
      vecs[1]  = '{32'h0000_1003, 32'h0, 3'b000, 1'b1, 1'b0, 5'd7, 0, 32'h80FF_0000, 1'b1,
                   32'h0000_1000, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80, 5'd7, 1'b0};
      vecs[2]  = '{32'h0000_2002, 32'h0, 3'b101, 1'b1, 1'b0, 5'd9, 2, 32'hBEEF_1234, 1'b1,
                   32'h0000_2000, 1'b0, 4'h0, 32'h0, 32'h0000_BEEF, 5'd9, 1'b0};
      vecs[3]  = '{32'h0000_3001, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 5'd3, 1, 32'h0, 1'b1,
                   32'h0000_3000, 1'b1, 4'b0010, 32'hDDDD_DDDD, 32'h0, 5'd0, 1'b0};
      vecs[4]  = '{32'h0000_4002, 32'h0, 3'b010, 1'b1, 1'b0, 5'd8, 0, 32'h0, 1'b0,
                   32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b1};
      vecs[5]  = '{32'h0000_4001, 32'h0000_1111, 3'b001, 1'b0, 1'b1, 5'd8, 0, 32'h0, 1'b0,
                   32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b1};
      vecs[6]  = '{32'h0000_5002, 32'h0, 3'b001, 1'b1, 1'b0, 5'd10, 0, 32'h8001_7FFF, 1'b1,
                   32'h0000_5000, 1'b0, 4'h0, 32'h0, 32'hFFFF_8001, 5'd10, 1'b0};
      vecs[7]  = '{32'h0000_6001, 32'h0, 3'b100, 1'b1, 1'b0, 5'd11, 1, 32'h1234_F0AB, 1'b1,
                   32'h0000_6000, 1'b0, 4'h0, 32'h0, 32'h0000_00F0, 5'd11, 1'b0};
      vecs[8]  = '{32'h0000_7000, 32'h0, 3'b010, 1'b1, 1'b0, 5'd31, 0, 32'hDEAD_BEEF, 1'b1,
                   32'h0000_7000, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF, 5'd31, 1'b0};
      vecs[9]  = '{32'h0000_8004, 32'h0123_4567, 3'b010, 1'b0, 1'b1, 5'd12, 0, 32'h0, 1'b1,
                   32'h0000_8004, 1'b1, 4'b1111, 32'h0123_4567, 32'h0, 5'd0, 1'b0};
      vecs[10] = '{32'h0000_9002, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 5'd13, 0, 32'h0, 1'b1,
                   32'h0000_9000, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0, 5'd0, 1'b0};
      vecs[11] = '{32'h0000_A000, 32'h0, 3'b011, 1'b1, 1'b0, 5'd14, 0, 32'h55AA_55AA, 1'b1,
                   32'h0000_A000, 1'b0, 4'h0, 32'h0, 32'h55AA_55AA, 5'd14, 1'b0};
      vecs[12] = '{32'h0000_B000, 32'hFFFF_FFFF, 3'b000, 1'b1, 1'b1, 5'd4, 0, 32'h0000_007F, 1'b1,
                   32'h0000_B000, 1'b0, 4'h0, 32'h0, 32'h0000_007F, 5'd4, 1'b0};
      vecs[13] = '{32'h0000_C002, 32'h0, 3'b000, 1'b1, 1'b0, 5'd15, 1, 32'h00C3_0000, 1'b1,
                   32'h0000_C000, 1'b0, 4'h0, 32'h0, 32'hFFFF_FFC3, 5'd15, 1'b0};
      vecs[14] = '{32'h0000_E000, 32'h0, 3'b010, 1'b1, 1'b0, 5'd16, TO, 32'h1357_9BDF, 1'b1,
                   32'h0000_E000, 1'b0, 4'h0, 32'h0, 32'h1357_9BDF, 5'd16, 1'b0};
      vecs[15] = '{32'h0000_5000, 32'h0, 3'b001, 1'b1, 1'b0, 5'd17, 0, 32'h1234_8000, 1'b1,
                   32'h0000_5000, 1'b0, 4'h0, 32'h0, 32'hFFFF_8000, 5'd17, 1'b0};

      rstn       = 1'b0;
      ex_valid   = 1'b0;
      alu_result = 32'h0;
      store_data = 32'h0;
      funct3     = 3'b000;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      rd_in      = 5'd0;
      dm_rdata   = 32'h0;
      dm_ack     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_dm_addr", dm_addr, 32'h0);
      chk("rst_dm_wstrb", {28'd0, dm_wstrb}, 32'd0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
      chk("rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
      rstn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         cur_vec = i;
         run_vec(vecs[i]);
      end

      // dm_ack while IDLE must not produce anything
      cur_vec = 100;
      @(negedge clk);
      dm_ack   = 1'b1;
      dm_rdata = 32'hCAFE_F00D;
      repeat (2) begin
         @(negedge clk);
         chk("idle_ack_wb", {31'd0, wb_valid}, 32'd0);
         chk("idle_ack_req", {31'd0, dm_req}, 32'd0);
      end
      dm_ack = 1'b0;

      // ex_valid held during BUSY: second op accepted only after the load completes
      cur_vec = 101;
      @(negedge clk);
      drive_op(32'h0000_0104, 32'h0, 3'b010, 1'b1, 1'b0, 5'd20);
      exp_q.push_back({32'h0BAD_F00D, 5'd20, 1'b0, 1'b0});
      exp_q.push_back({32'h0000_0077, 5'd2, 1'b0, 1'b0});
      @(negedge clk);
      drive_op(32'h0000_0077, 32'h0, 3'b000, 1'b0, 1'b0, 5'd2);
      chk("hold_busy_ready", {31'd0, ex_ready}, 32'd0);
      @(negedge clk);
      chk("hold_busy_ready2", {31'd0, ex_ready}, 32'd0);
      dm_ack   = 1'b1;
      dm_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      dm_ack = 1'b0;
      chk("hold_ld_wb", {31'd0, wb_valid}, 32'd1);
      chk("hold_req_drop", {31'd0, dm_req}, 32'd0);
      @(negedge clk);
      ex_valid = 1'b0;
      chk("hold_alu_wb", {31'd0, wb_valid}, 32'd1);

      // timeout: no ack ever
      cur_vec = 102;
      @(negedge clk);
      drive_op(32'h0000_D000, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6);
      exp_q.push_back({32'h0, 5'd0, 1'b0, 1'b1});
      @(negedge clk);
      ex_valid = 1'b0;
      req_cnt  = 0;
      guard    = 0;
      while (wb_valid !== 1'b1 && guard < 50) begin
         if (dm_req === 1'b1) req_cnt++;
         @(negedge clk);
         guard++;
      end
      chk("timeout_bound", {31'd0, guard < 50}, 32'd1);
      chk("timeout_req_cycles", req_cnt, TO + 1);
      chk("timeout_req_drop", {31'd0, dm_req}, 32'd0);
      chk("timeout_ready", {31'd0, ex_ready}, 32'd1);

      // asynchronous reset while BUSY drops dm_req without a clock edge
      cur_vec = 103;
      @(negedge clk);
      drive_op(32'h0000_F000, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9);
      @(negedge clk);
      ex_valid = 1'b0;
      chk("arst_pre_req", {31'd0, dm_req}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("arst_dm_req", {31'd0, dm_req}, 32'd0);
      chk("arst_ready", {31'd0, ex_ready}, 32'd1);
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("arst_idle_req", {31'd0, dm_req}, 32'd0);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
